fir_tap_loader: RTL and testbench
=================================

Name: fir_tap_loader

Overview:
Initiator side of the reloadable FIR tap-write interface. It holds a host-writable bank of NTAPS coefficients and, on command, streams them into a filter's serial tap chain, one write per cycle. It gates the filter's sample strobe while loading, then flags the output as valid once the delay line has refilled. It sits between the host register bus and the FIR's tap-write, sample-enable and result-qualifier signals.

Parameters:
NTAPS, 43, number of filter taps (coefficients streamed per load)
TW, 12, coefficient width
AW, 6, coefficient address width; 2^AW >= NTAPS required

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_cfg_wr  in  1  host coefficient write strobe
i_cfg_addr  in  AW  coefficient index 0..NTAPS-1
i_cfg_data  in  TW  coefficient value
o_cfg_busy  out  1  high in LOAD; host writes are rejected
o_cfg_err  out  1  one-cycle pulse on a rejected host write
i_load  in  1  start-load pulse
i_ce  in  1  upstream sample strobe
o_ce  out  1  gated sample strobe to the FIR
o_tap_wr  out  1  tap write strobe to the FIR
o_tap  out  TW  tap value to the FIR
o_done  out  1  one-cycle pulse when the last tap is written
o_valid  out  1  filter output qualifier

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0, o_valid 0, counters 0. Coefficient RAM contents are not reset.
- Coefficient RAM: NTAPS x TW, one write port and one registered read port (1-cycle latency).
- Host write: accepted when i_cfg_wr=1, state is not LOAD, and i_cfg_addr<NTAPS. The RAM updates at that clock edge.
- Rejected write: any write in LOAD, or any write with addr>=NTAPS. The RAM is unchanged and o_cfg_err pulses on the next cycle.
- FSM states: IDLE, LOAD, FLUSH.
- IDLE -> LOAD: on i_load=1. The read pointer is set to 0 and o_valid clears.
- i_load while in LOAD: ignored.
- i_load while in FLUSH: restarts LOAD from pointer 0.
- LOAD: read pointer advances 0..NTAPS-1, one per cycle.
  - o_tap_wr=1 with o_tap=c[k] exactly one cycle after address k is read.
  - Timing: i_load sampled at edge 0 gives tap writes on cycles 2..NTAPS+1, back-to-back with no gaps.
  - Emission order is c[0] first, c[NTAPS-1] last.
- o_done: pulses in the cycle after the final o_tap_wr. The FSM enters FLUSH in the same cycle.
- o_tap: holds its last value when o_tap_wr=0; 0 after reset.
- o_ce: equals i_ce combinationally in IDLE and FLUSH; forced to 0 in LOAD and during the trailing tap-write cycle.
- FLUSH: counts o_ce strobes. After NTAPS strobes, o_valid is set and the FSM returns to IDLE. o_valid stays set until the next i_load or reset.
- Flush counter: ceil(log2(NTAPS+1)) bits, saturating.
- Reset asserted mid-LOAD: the load aborts immediately. The FIR holds a partial tap set, and o_valid stays 0 until a complete LOAD followed by FLUSH.
- Simultaneous i_load and accepted i_cfg_wr in IDLE: the write commits first, so the new value is emitted.

Test Plan:
- Write c[k]=k+1 (k=0..42), pulse i_load -> o_tap_wr high cycles 2..44 with o_tap=1..43 in order; o_done at cycle 45; o_cfg_busy high throughout LOAD.
- i_ce held 1 through the load -> o_ce=0 for cycles 1..44; o_valid rises after the 43rd post-load o_ce strobe.
- i_cfg_wr at cycle 10 of LOAD -> o_cfg_err pulses; a second load shows the RAM word unchanged. i_cfg_wr with addr=50 in IDLE -> o_cfg_err pulses, no RAM change.
- i_load pulsed again at LOAD cycle 20 -> ignored; exactly 43 tap writes total and a single o_done.
- Assert i_reset_n=0 at LOAD cycle 15 -> o_tap_wr, o_done and o_valid drop to 0 asynchronously. After release, a full load + flush sets o_valid.
- Accepted write of c[0]=0xABC and i_load in the same IDLE cycle -> first o_tap=0xABC.

Source files
------------

// File: rtl/fir_tap_loader.sv
// FIR coefficient bank and tap-chain streamer: holds NTAPS host-written taps,
// streams them into the filter on i_load, then qualifies the output after a refill.
module fir_tap_loader #(
    parameter int NTAPS = 43,
    parameter int TW    = 12,
    parameter int AW    = 6
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_cfg_wr,
    input  logic [AW-1:0] i_cfg_addr,
    input  logic [TW-1:0] i_cfg_data,
    output logic          o_cfg_busy,
    output logic          o_cfg_err,
    input  logic          i_load,
    input  logic          i_ce,
    output logic          o_ce,
    output logic          o_tap_wr,
    output logic [TW-1:0] o_tap,
    output logic          o_done,
    output logic          o_valid
);
    localparam int CW = $clog2(NTAPS + 1);
    localparam logic [AW:0]   PTR_END = (AW + 1)'(NTAPS);
    localparam logic [CW-1:0] CNT_END = CW'(NTAPS);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FLUSH = 2'd2} state_t;
    state_t state, state_nxt;

    logic [TW-1:0] coef [NTAPS];
    // One bit wider than the address so the pointer can sit at NTAPS for the trailing cycle.
    logic [AW:0]   ptr;
    logic [CW-1:0] fcnt;
    logic          in_load, load_go, wr_ok, rd_en, load_end, flush_hit;

    always_comb begin
        in_load   = (state == LOAD);
        load_go   = i_load && !in_load;
        wr_ok     = i_cfg_wr && !in_load && ({1'b0, i_cfg_addr} < PTR_END);
        rd_en     = in_load && (ptr != PTR_END);
        load_end  = in_load && (ptr == PTR_END);
        flush_hit = (state == FLUSH) && i_ce && (fcnt == CNT_END - CW'(1));
    end

    assign o_cfg_busy = in_load;
    assign o_ce       = i_ce && !in_load;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_load) state_nxt = LOAD;
            LOAD:    if (load_end) state_nxt = FLUSH;
            FLUSH: begin
                if (i_load)         state_nxt = LOAD;
                else if (flush_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write port: a same-cycle write and i_load both land before the first read.
    always_ff @(posedge i_clk) begin
        if (wr_ok) coef[i_cfg_addr] <= i_cfg_data;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ptr       <= '0;
            fcnt      <= '0;
            o_tap     <= '0;
            o_tap_wr  <= 1'b0;
            o_done    <= 1'b0;
            o_valid   <= 1'b0;
            o_cfg_err <= 1'b0;
        end else begin
            o_cfg_err <= i_cfg_wr && !wr_ok;
            o_tap_wr  <= rd_en;
            o_done    <= load_end;
            if (rd_en) begin
                o_tap <= coef[ptr[AW-1:0]];
                ptr   <= ptr + 1'b1;
            end
            if (load_go) begin
                ptr     <= '0;
                fcnt    <= '0;
                o_valid <= 1'b0;
            end else if (state == FLUSH && i_ce) begin
                if (fcnt != CNT_END) fcnt <= fcnt + 1'b1;
                if (flush_hit)       o_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fir_tap_loader.sv
// Randomized scoreboard bench for fir_tap_loader: a timeline model predicts
// busy/ce/tap/done/valid/err per cycle and queues the expected tap stream per load.
module tb_fir_tap_loader;
    localparam int NTAPS = 43;
    localparam int TW    = 12;
    localparam int AW    = 6;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_cfg_wr;
    logic [AW-1:0] i_cfg_addr;
    logic [TW-1:0] i_cfg_data;
    logic          o_cfg_busy, o_cfg_err;
    logic          i_load, i_ce, o_ce, o_tap_wr, o_done, o_valid;
    logic [TW-1:0] o_tap;

    fir_tap_loader #(.NTAPS(NTAPS), .TW(TW), .AW(AW)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_cfg_wr(i_cfg_wr),
        .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data), .o_cfg_busy(o_cfg_busy),
        .o_cfg_err(o_cfg_err), .i_load(i_load), .i_ce(i_ce), .o_ce(o_ce),
        .o_tap_wr(o_tap_wr), .o_tap(o_tap), .o_done(o_done), .o_valid(o_valid)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a load sampled at an edge makes the next period offset 0;
    // offsets 0..NTAPS are busy, 1..NTAPS carry c[off-1], NTAPS+1 is done, then flush.
    int            cyc = 0;
    int            lc = 0;
    bit            active = 0;
    bit            mvalid = 0;
    bit            err_exp = 0;
    bit            mbusy;
    int            strobes = 0;
    logic [TW-1:0] coef_m [NTAPS];
    logic [TW-1:0] exp_q [$];

    always @(posedge i_clk) begin
        if (!i_reset_n) begin
            active = 0; mvalid = 0; err_exp = 0; strobes = 0;
            exp_q.delete();
        end else begin
            mbusy   = active && (cyc - lc) >= 0 && (cyc - lc) <= NTAPS;
            err_exp = i_cfg_wr && (mbusy || i_cfg_addr >= NTAPS);
            if (i_cfg_wr && !mbusy && i_cfg_addr < NTAPS) coef_m[i_cfg_addr] = i_cfg_data;
            if (i_load && !mbusy) begin
                lc = cyc + 1; active = 1; mvalid = 0; strobes = 0;
                for (int k = 0; k < NTAPS; k++) exp_q.push_back(coef_m[k]);
            end else if (active && !mvalid && (cyc - lc) >= NTAPS + 1 && i_ce) begin
                strobes++;
                if (strobes == NTAPS) mvalid = 1;
            end
        end
        cyc++;
    end

    // Monitor: samples on the falling edge, inputs only change just after rising edges.
    int off;
    bit eb;
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            off = cyc - lc;
            eb  = active && off >= 0 && off <= NTAPS;
            chk("busy",   o_cfg_busy, eb);
            chk("tap_wr", o_tap_wr,   active && off >= 1 && off <= NTAPS);
            chk("done",   o_done,     active && off == NTAPS + 1);
            chk("ce",     o_ce,       eb ? 1'b0 : i_ce);
            chk("cfg_err", o_cfg_err, err_exp);
            chk("valid",  o_valid,    mvalid);
            if (o_tap_wr) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tap_extra actual=%0h expected=none t=%0t", o_tap, $time);
                end else begin
                    chk("tap", o_tap, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic cfg_write(input int a, input int d);
        i_cfg_wr = 1'b1; i_cfg_addr = AW'(a); i_cfg_data = TW'(d);
        step(1);
        i_cfg_wr = 1'b0;
    endtask

    task automatic pulse_load();
        i_load = 1'b1;
        step(1);
        i_load = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!o_valid && n < 300) begin step(1); n++; end
        chk(name, o_valid, 1'b1);
    endtask

    initial begin
        i_reset_n = 1'b0; i_cfg_wr = 1'b0; i_cfg_addr = '0; i_cfg_data = '0;
        i_load = 1'b0; i_ce = 1'b0;
        step(3);
        chk("rst_tap_wr", o_tap_wr, 0);
        chk("rst_tap",    o_tap, 0);
        chk("rst_done",   o_done, 0);
        chk("rst_valid",  o_valid, 0);
        chk("rst_busy",   o_cfg_busy, 0);
        chk("rst_err",    o_cfg_err, 0);
        i_reset_n = 1'b1;
        step(1);

        // Ramp coefficients, load with i_ce held high, reject a write at cycle 10,
        // ignore a second i_load at cycle 20.
        i_ce = 1'b1;
        for (int k = 0; k < NTAPS; k++) cfg_write(k, k + 1);
        pulse_load();
        step(9);
        cfg_write(5, 'hFFF);
        step(9);
        pulse_load();
        wait_valid("valid_after_first_load");
        step(3);

        // Out-of-range write in IDLE, then reload to show c[5] unchanged.
        cfg_write(50, 'h123);
        step(2);
        pulse_load();
        wait_valid("valid_after_second_load");

        // Write and load in the same idle cycle.
        i_cfg_wr = 1'b1; i_cfg_addr = '0; i_cfg_data = TW'('hABC); i_load = 1'b1;
        step(1);
        i_cfg_wr = 1'b0; i_load = 1'b0;

        // Reset mid-load at cycle 15.
        step(14);
        i_reset_n = 1'b0;
        #1;
        chk("abort_tap_wr", o_tap_wr, 0);
        chk("abort_done",   o_done, 0);
        chk("abort_valid",  o_valid, 0);
        step(2);
        i_reset_n = 1'b1;
        step(2);
        chk("post_abort_valid", o_valid, 0);
        pulse_load();
        wait_valid("valid_after_abort_reload");

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            i_ce       = 1'($urandom_range(0, 1));
            i_cfg_wr   = ($urandom_range(0, 7) == 0);
            i_cfg_addr = AW'($urandom_range(0, 63));
            i_cfg_data = TW'($urandom);
            i_load     = ($urandom_range(0, 59) == 0);
            step(1);
            i_cfg_wr = 1'b0; i_load = 1'b0;
        end
        i_ce = 1'b1;
        step(150);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
